pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
Sequences the 50->100 MHz PLL's reset and lock-acquisition process, running on the free-running reference clock. It pulses the PLL reset, waits for a qualified, debounced lock, and then releases the downstream system reset. It re-sequences on loss of lock or on request, and latches a fault after repeated lock failures. It sits between the board reset and the PLL wrapper, and feeds the PHY reset tree.

Parameters:
RST_CYCLES, 16, refclk cycles PLL reset held high per attempt (>=1)
LOCK_TIMEOUT, 50000, max refclk cycles from PLL reset release to qualified lock (1 ms at 50 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (>=1)
MAX_RETRIES, 3, lock retries allowed before FAULT (0..255)

Ports:
refclk  input  1  reference clock, 50 MHz, free-running; the only clock
rst  input  1  asynchronous, active-high reset
pll_locked  input  1  PLL locked output; asynchronous to refclk
relock_req  input  1  single-cycle request to re-sequence the PLL
pll_rst  output  1  drives the PLL rst input, active high
sys_rst  output  1  downstream system reset, active high
pll_ready  output  1  high only in RUN
fault  output  1  high only in FAULT
retry_cnt  output  8  failed attempts in the current sequence
loss_cnt  output  8  lock losses seen in RUN, saturates at 255
state_o  output  3  current state encoding, for debug

Behaviour:
- Reset values (on async rst): state=RESET_PLL, pll_rst=1, sys_rst=1, pll_ready=0, fault=0, retry_cnt=0, loss_cnt=0, all counters=0.
- Reset is deasserted with a synchronous release.
- pll_locked passes through a 2-flop synchronizer to give lock_s, which adds 2 cycles of latency. The FSM uses only lock_s.
- All outputs are registered and decoded from the current state:
  - pll_rst = (state==RESET_PLL)
  - sys_rst = (state!=RUN)
  - pll_ready = (state==RUN)
  - fault = (state==FAULT)
- State encodings: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- RESET_PLL:
  - rst_cnt counts from 0 up to RST_CYCLES-1.
  - On the last count, go to WAIT_LOCK and clear tmo_cnt.
  - pll_rst is therefore high for exactly RST_CYCLES cycles per entry.
- WAIT_LOCK:
  - tmo_cnt increments every cycle.
  - If lock_s=1, go to STABLE with stab_cnt=0.
- STABLE:
  - tmo_cnt keeps incrementing.
  - stab_cnt increments while lock_s=1.
  - If lock_s=0, return to WAIT_LOCK. tmo_cnt is not cleared, so lock flapping still times out.
  - When stab_cnt reaches STABLE_CYCLES-1 with lock_s=1, go to RUN.
- Timeout, in WAIT_LOCK or STABLE, when tmo_cnt reaches LOCK_TIMEOUT-1:
  - If retry_cnt==MAX_RETRIES, go to FAULT.
  - Otherwise increment retry_cnt and go to RESET_PLL.
  - Timeout takes priority over a same-cycle STABLE->RUN transition.
- RUN:
  - If lock_s=0, go to RESET_PLL, increment loss_cnt (saturating) and clear retry_cnt.
  - sys_rst reasserts the cycle after the drop is seen on lock_s.
- FAULT: remain in FAULT, with pll_rst=0 and sys_rst=1, until relock_req or rst.
- relock_req:
  - Honoured only in RUN and FAULT. It sends the FSM to RESET_PLL and clears retry_cnt.
  - Ignored in RESET_PLL, WAIT_LOCK and STABLE.
  - relock_req and lock loss in the same RUN cycle give one transition to RESET_PLL, and loss_cnt still increments.
- Minimum time from rst release to sys_rst=0: RST_CYCLES + 2 (sync) + STABLE_CYCLES + 1 cycles, assuming pll_locked is already high.
- Counter widths are $clog2 of each bound, minimum 1 bit. Equality compares are used, and no counter wraps.
- rst asserted mid-sequence immediately forces the reset values, including pll_rst=1.

Decomposition:
- Package pll_sup_pkg: state enum with the fixed encodings above, and a function returning counter width from a bound.
- Sub-module sync_2ff (1-bit, 2-stage, async active-high reset to 0) for pll_locked.
- The FSM and counters stay in pll_lock_supervisor.

Test Plan:
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Release rst with pll_locked held high -> pll_rst high for exactly 4 cycles; sys_rst falls and pll_ready rises 4+2+8+1=15 cycles after rst release; retry_cnt=0.
2. pll_locked held low -> three pll_rst pulses, each 4 cycles long and 64 cycles apart; retry_cnt steps 1 then 2; fault=1 at the third timeout; sys_rst stays 1.
3. In RUN, drop pll_locked for 1 cycle -> sys_rst=1 three cycles later; loss_cnt=1; pll_rst pulses for 4 cycles; RUN re-entered after lock returns plus 8 qualified cycles.
4. Toggle pll_locked every 5 cycles during STABLE -> never reaches RUN; timeout occurs 64 cycles after WAIT_LOCK entry; retry_cnt increments.
5. From FAULT, pulse relock_req -> RESET_PLL next cycle; fault=0; retry_cnt=0. The same pulse sent during WAIT_LOCK has no effect.
6. Assert rst during STABLE -> the same cycle (async) gives pll_rst=1, sys_rst=1, loss_cnt=0, state_o=0.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } sup_state_e;

  // Bits needed to count 0..bound-1, never less than one.
  function automatic int cnt_width(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer, async active-high reset to 0.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer on refclk: pulses pll_rst, qualifies lock, releases sys_rst.
// Latency: lock_s lags pll_locked by 2 cycles; outputs are registered decodes of state.
// Backpressure: none; relock_req is a single-cycle pulse honoured only in RUN and FAULT.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic       fault,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_o
);

  localparam int RW = cnt_width(RST_CYCLES);
  localparam int TW = cnt_width(LOCK_TIMEOUT);
  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRIES);

  logic rst_rel;
  logic rst_int;
  logic lock_s;
  logic timeout;

  sup_state_e    state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [7:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;

  // Assertion is immediate, release is re-timed by two refclk flops.
  sync_2ff u_rst_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (1'b1),
    .q_o   (rst_rel)
  );
  assign rst_int = ~rst_rel;

  sync_2ff u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst_int),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  assign timeout = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge refclk or posedge rst_int) begin
    if (rst_int) begin
      state_q    <= ST_RESET_PLL;
      rst_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      stab_cnt_q <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      pll_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      pll_rst_q  <= pll_rst_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    stab_cnt_d = stab_cnt_q;
    retry_d    = retry_q;
    loss_d     = loss_q;
    case (state_q)
      ST_RESET_PLL: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = ST_WAIT_LOCK;
          rst_cnt_d = '0;
          tmo_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        // The timeout budget spans both states so a flapping lock still expires.
        if (timeout) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = ST_RESET_PLL;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (state_q == ST_WAIT_LOCK) begin
            if (lock_s) begin
              state_d    = ST_STABLE;
              stab_cnt_d = '0;
            end
          end else if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (stab_cnt_q == STAB_LAST) begin
            state_d = ST_RUN;
          end else begin
            stab_cnt_d = stab_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!lock_s || relock_req) begin
          state_d = ST_RESET_PLL;
          retry_d = '0;
          if (!lock_s && loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
          end
        end
      end
      ST_FAULT: begin
        if (relock_req) begin
          state_d = ST_RESET_PLL;
          retry_d = '0;
        end
      end
      default: state_d = ST_RESET_PLL;
    endcase
  end

  always_comb begin
    pll_rst_d = (state_d == ST_RESET_PLL);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign pll_ready = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus randomized lock traffic vs a behavioural model.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 64;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst, pll_ready, fault;
  logic [7:0] retry_cnt, loss_cnt;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .pll_ready  (pll_ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt),
    .state_o    (state_o)
  );

  always #10 refclk = ~refclk;

  // Behavioural model: phase plus elapsed-cycle bookkeeping.
  // Phases: 0 PLL reset, 1 waiting, 2 qualifying, 3 running, 4 fault.
  int m_rel, m_ph, m_left, m_since, m_run, m_retry, m_loss;
  bit m_s1, m_s2, m_ls;

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      m_rel = 0; m_s1 = 0; m_s2 = 0; m_ph = 0; m_left = RST_CYCLES;
      m_since = 0; m_run = 0; m_retry = 0; m_loss = 0;
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      m_ls = m_s2; m_s2 = m_s1; m_s1 = pll_locked;
      case (m_ph)
        0: begin
          m_left--;
          if (m_left == 0) begin m_ph = 1; m_since = 0; end
        end
        1, 2: begin
          m_since++;
          if (m_since == LOCK_TIMEOUT) begin
            if (m_retry == MAX_RETRIES) m_ph = 4;
            else begin m_retry++; m_ph = 0; m_left = RST_CYCLES; end
          end else if (m_ph == 1) begin
            if (m_ls) begin m_ph = 2; m_run = 0; end
          end else if (!m_ls) begin
            m_ph = 1;
          end else begin
            m_run++;
            if (m_run == STABLE_CYCLES) m_ph = 3;
          end
        end
        3: if (!m_ls || relock_req) begin
          if (!m_ls && m_loss < 255) m_loss++;
          m_retry = 0; m_ph = 0; m_left = RST_CYCLES;
        end
        default: if (relock_req) begin
          m_retry = 0; m_ph = 0; m_left = RST_CYCLES;
        end
      endcase
    end
  end

  logic [22:0] m_vec, dut_vec;
  always_comb m_vec = {3'(m_ph), m_ph == 0, m_ph != 3, m_ph == 3, m_ph == 4, 8'(m_retry), 8'(m_loss)};
  assign dut_vec = {state_o, pll_rst, sys_rst, pll_ready, fault, retry_cnt, loss_cnt};

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    repeat (3) @(negedge refclk);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state_o); end
    checks++;
    if ({pll_rst, sys_rst, pll_ready, fault} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags got=%b want=1100", {pll_rst, sys_rst, pll_ready, fault});
    end
    checks++;
    if (retry_cnt !== 8'd0 || loss_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_counts retry=%0d loss=%0d want=0,0", retry_cnt, loss_cnt);
    end
    checks++;
    if (dut_vec !== m_vec) begin errors++; $display("FAIL reset_model dut=%h model=%h", dut_vec, m_vec); end
  endtask

  task automatic test_power_up();
    int rst_fall = -1;
    int run_at = -1;
    pll_locked = 1'b1; rst = 1'b0;
    for (int n = 1; n <= 40 && run_at < 0; n++) begin
      @(negedge refclk);
      checks++;
      if (dut_vec !== m_vec) begin errors++; $display("FAIL up_model n=%0d dut=%h model=%h", n, dut_vec, m_vec); end
      if (rst_fall < 0 && !pll_rst) rst_fall = n;
      if (run_at < 0 && !sys_rst) run_at = n;
    end
    // Two release-retiming cycles precede the RST_CYCLES pulse.
    checks++;
    if (rst_fall != RST_CYCLES + 2) begin errors++; $display("FAIL up_pll_rst_fall got=%0d want=%0d", rst_fall, RST_CYCLES + 2); end
    checks++;
    if (run_at != RST_CYCLES + 2 + STABLE_CYCLES + 1) begin
      errors++; $display("FAIL up_sys_rst_release got=%0d want=%0d", run_at, RST_CYCLES + 2 + STABLE_CYCLES + 1);
    end
    checks++;
    if (pll_ready !== 1'b1 || retry_cnt !== 8'd0 || state_o !== 3'd3) begin
      errors++; $display("FAIL up_run ready=%b retry=%0d state=%0d want=1,0,3", pll_ready, retry_cnt, state_o);
    end
  endtask

  task automatic test_loss();
    int sys_at = -1, rst_hi = 0, run_at = -1, loss_seen = -1;
    pll_locked = 1'b0;
    for (int n = 1; n <= 40 && run_at < 0; n++) begin
      @(negedge refclk);
      checks++;
      if (dut_vec !== m_vec) begin errors++; $display("FAIL loss_model n=%0d dut=%h model=%h", n, dut_vec, m_vec); end
      if (n == 1) pll_locked = 1'b1;
      if (sys_at < 0 && sys_rst) begin sys_at = n; loss_seen = loss_cnt; end
      if (pll_rst) rst_hi++;
      if (sys_at > 0 && run_at < 0 && pll_ready) run_at = n;
    end
    checks++;
    if (sys_at != 3) begin errors++; $display("FAIL loss_sys_rst_delay got=%0d want=3", sys_at); end
    checks++;
    if (loss_seen != 1) begin errors++; $display("FAIL loss_cnt got=%0d want=1", loss_seen); end
    checks++;
    if (rst_hi != RST_CYCLES) begin errors++; $display("FAIL loss_pll_rst_width got=%0d want=%0d", rst_hi, RST_CYCLES); end
    checks++;
    if (run_at != 3 + RST_CYCLES + 1 + STABLE_CYCLES) begin
      errors++; $display("FAIL loss_rerun got=%0d want=%0d", run_at, 3 + RST_CYCLES + 1 + STABLE_CYCLES);
    end
  endtask

  task automatic test_async_rst();
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    checks++;
    if (state_o !== 3'd0 || loss_cnt !== 8'd1 || retry_cnt !== 8'd0) begin
      errors++; $display("FAIL relock_in_run state=%0d loss=%0d retry=%0d want=0,1,0", state_o, loss_cnt, retry_cnt);
    end
    for (int n = 0; n < 30 && state_o !== 3'd2; n++) begin
      @(negedge refclk);
      checks++;
      if (dut_vec !== m_vec) begin errors++; $display("FAIL arst_model n=%0d dut=%h model=%h", n, dut_vec, m_vec); end
    end
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL arst_reach_stable got=%0d want=2", state_o); end
    #5 rst = 1'b1;
    #1;
    checks++;
    if ({state_o, pll_rst, sys_rst, pll_ready, fault} !== 7'b000_1100 || loss_cnt !== 8'd0 || retry_cnt !== 8'd0) begin
      errors++; $display("FAIL arst_immediate got state=%0d flags=%b loss=%0d want 0,1100,0", state_o,
                         {pll_rst, sys_rst, pll_ready, fault}, loss_cnt);
    end
    @(negedge refclk);
  endtask

  task automatic test_timeout();
    int rise_t[3], fall_t[3], rret[3];
    int rises = 0, falls = 0, fault_at = -1;
    bit prev = 1'b1, sys_low = 1'b0;
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    @(negedge refclk);
    rst = 1'b0;
    rise_t[0] = 0; rret[0] = 0;
    for (int n = 1; n <= 300 && fault_at < 0; n++) begin
      @(negedge refclk);
      checks++;
      if (dut_vec !== m_vec) begin errors++; $display("FAIL tmo_model n=%0d dut=%h model=%h", n, dut_vec, m_vec); end
      if (pll_rst && !prev && rises < 2) begin rises++; rise_t[rises] = n; rret[rises] = retry_cnt; end
      if (!pll_rst && prev && falls < 3) begin fall_t[falls] = n; falls++; end
      if (!sys_rst) sys_low = 1'b1;
      if (fault) fault_at = n;
      prev = pll_rst;
    end
    checks++;
    if (rises != 2 || falls != 3) begin errors++; $display("FAIL tmo_pulses rises=%0d falls=%0d want=2,3", rises, falls); end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (rise_t[i] - fall_t[i-1] != LOCK_TIMEOUT) begin
        errors++; $display("FAIL tmo_gap%0d got=%0d want=%0d", i, rise_t[i] - fall_t[i-1], LOCK_TIMEOUT);
      end
      checks++;
      if (fall_t[i] - rise_t[i] != RST_CYCLES) begin
        errors++; $display("FAIL tmo_width%0d got=%0d want=%0d", i, fall_t[i] - rise_t[i], RST_CYCLES);
      end
      checks++;
      if (rret[i] != i) begin errors++; $display("FAIL tmo_retry%0d got=%0d want=%0d", i, rret[i], i); end
    end
    checks++;
    if (fault_at != RST_CYCLES + 2 + 3 * LOCK_TIMEOUT + 2 * RST_CYCLES) begin
      errors++; $display("FAIL tmo_fault_time got=%0d want=%0d", fault_at, RST_CYCLES + 2 + 3 * LOCK_TIMEOUT + 2 * RST_CYCLES);
    end
    checks++;
    if (sys_low) begin errors++; $display("FAIL tmo_sys_rst got=0 want=1 throughout"); end
  endtask

  task automatic test_fault_relock();
    repeat (5) begin
      @(negedge refclk);
      checks++;
      if ({fault, pll_rst, sys_rst} !== 3'b101) begin
        errors++; $display("FAIL fault_hold got=%b want=101", {fault, pll_rst, sys_rst});
      end
    end
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    checks++;
    if (state_o !== 3'd0 || fault !== 1'b0 || retry_cnt !== 8'd0) begin
      errors++; $display("FAIL fault_relock state=%0d fault=%b retry=%0d want=0,0,0", state_o, fault, retry_cnt);
    end
    for (int n = 0; n < 20 && state_o !== 3'd1; n++) @(negedge refclk);
    relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    checks++;
    if (state_o !== 3'd1 || pll_rst !== 1'b0) begin
      errors++; $display("FAIL wait_relock_ignored state=%0d pll_rst=%b want=1,0", state_o, pll_rst);
    end
  endtask

  task automatic test_flap();
    int wait_at = -1, tmo_at = -1, tmo_retry = -1;
    bit saw_stable = 1'b0, saw_run = 1'b0;
    rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0; pll_locked = 1'b1;
    for (int n = 1; n <= 200 && tmo_at < 0; n++) begin
      @(negedge refclk);
      checks++;
      if (dut_vec !== m_vec) begin errors++; $display("FAIL flap_model n=%0d dut=%h model=%h", n, dut_vec, m_vec); end
      pll_locked = ((n / 5) % 2) == 0;
      if (wait_at < 0 && state_o === 3'd1) wait_at = n;
      if (state_o === 3'd2) saw_stable = 1'b1;
      if (pll_ready) saw_run = 1'b1;
      if (wait_at > 0 && state_o === 3'd0) begin tmo_at = n; tmo_retry = retry_cnt; end
    end
    checks++;
    if (tmo_at - wait_at != LOCK_TIMEOUT) begin
      errors++; $display("FAIL flap_timeout got=%0d want=%0d", tmo_at - wait_at, LOCK_TIMEOUT);
    end
    checks++;
    if (!saw_stable || saw_run) begin errors++; $display("FAIL flap_states stable=%b run=%b want=1,0", saw_stable, saw_run); end
    checks++;
    if (tmo_retry != 1) begin errors++; $display("FAIL flap_retry got=%0d want=1", tmo_retry); end
  endtask

  task automatic test_random();
    int run_len = 0;
    int runs = 0;
    rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge refclk);
      checks++;
      if (dut_vec !== m_vec) begin errors++; $display("FAIL rand_model n=%0d dut=%h model=%h", n, dut_vec, m_vec); end
      if (pll_ready) runs++;
      if (run_len == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        run_len = $urandom_range(1, 40);
      end
      run_len--;
      relock_req = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0; relock_req = 1'b0;
    checks++;
    if (runs == 0) begin errors++; $display("FAIL rand_run_reached got=0 want>0"); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_loss();
    test_async_rst();
    test_timeout();
    test_fault_relock();
    test_flap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
